// File: rtl/aes_enc_arbiter.sv
// Round-robin arbiter sharing one iterative AES encipher core between two
// requesters; times the core latency and returns ciphertext to the winner.
module aes_enc_arbiter #(
    parameter int Nk       = 4,
    parameter int CORE_LAT = Nk + 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_data0,
    input  logic [127:0] req_data1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [127:0] rsp_data,
    output logic         core_enable,
    output logic [127:0] core_load,
    input  logic [127:0] core_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_t;

    localparam logic [4:0] LAT = 5'(CORE_LAT);

    state_t     state;
    logic       ptr;
    logic       grant;
    logic       gsel;
    logic [4:0] cnt;

    // Pointer holder wins a tie; otherwise whichever requester is valid.
    assign gsel = req_valid[ptr] ? ptr : ~ptr;

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && reset && (|req_valid))
            req_ready[gsel] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            grant       <= 1'b0;
            cnt         <= '0;
            rsp_valid   <= 2'b00;
            rsp_data    <= '0;
            core_enable <= 1'b0;
            core_load   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        core_load   <= gsel ? req_data1 : req_data0;
                        grant       <= gsel;
                        core_enable <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    core_enable <= 1'b0;
                    cnt         <= 5'd1;
                    state       <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAT) begin
                        rsp_data  <= core_out;
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Only the granted requester's accept ends the response.
                    if (rsp_ready[grant]) begin
                        rsp_valid <= 2'b00;
                        ptr       <= ~grant;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
